// File: rtl/ula_operand_stage.sv
// Operand-fetch stage feeding the ULA: 32x32 register file with writeback bypass,
// operand select, select-code legality check, one-stage output register. Optional: OPERAND_SHAMT_MASK_EN.
module ula_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [ADDR_WIDTH-1:0] rs1_in,
    input  logic [ADDR_WIDTH-1:0] rs2_in,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    input  logic [DATA_WIDTH-1:0] imm_in,
    input  logic                  use_imm_in,
    input  logic [3:0]            select_ula_in,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  wb_en_in,
    input  logic [ADDR_WIDTH-1:0] wb_addr_in,
    input  logic [DATA_WIDTH-1:0] wb_data_in,
    output logic [DATA_WIDTH-1:0] data1_out,
    output logic [DATA_WIDTH-1:0] data2_out,
    output logic [3:0]            select_ula_out,
    output logic [ADDR_WIDTH-1:0] rd_out,
    output logic                  valid_out,
    output logic                  illegal_op_out
);

    // Handshake: an operation transfers on a rising edge where valid_in=1 and
    // ready_out=1; while ready_out=0 the upstream stage holds its inputs stable.
    assign ready_out = !stall_in;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] op2_final;
    logic                  code_legal;
    logic                  is_shift;

    // x0 reads as zero; a same-cycle writeback to the read index is forwarded.
    always_comb begin
        rd1 = '0;
        if (rs1_in != '0) begin
            rd1 = (wb_en_in && (wb_addr_in == rs1_in)) ? wb_data_in : regs[rs1_in];
        end
        rd2 = '0;
        if (rs2_in != '0) begin
            rd2 = (wb_en_in && (wb_addr_in == rs2_in)) ? wb_data_in : regs[rs2_in];
        end
    end

    assign op2        = use_imm_in ? imm_in : rd2;
    assign code_legal = (select_ula_in >= 4'd1) && (select_ula_in <= 4'd10);
    assign is_shift   = (select_ula_in == 4'b0011) || (select_ula_in == 4'b0110) ||
                        (select_ula_in == 4'b0111);

`ifdef OPERAND_SHAMT_MASK_EN
    assign op2_final = is_shift ? {{(DATA_WIDTH-5){1'b0}}, op2[4:0]} : op2;
`else
    assign op2_final = op2;
    logic unused_shift;
    assign unused_shift = is_shift;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_in && (wb_addr_in != '0)) begin
            regs[wb_addr_in] <= wb_data_in;
        end
    end

    // Pipeline register: flush beats stall; stall freezes everything but the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            data1_out      <= '0;
            data2_out      <= '0;
            select_ula_out <= '0;
            rd_out         <= '0;
            valid_out      <= 1'b0;
            illegal_op_out <= 1'b0;
        end else if (flush_in) begin
            valid_out      <= 1'b0;
            illegal_op_out <= 1'b0;
        end else if (stall_in) begin
            illegal_op_out <= 1'b0;
        end else if (valid_in && code_legal) begin
            data1_out      <= rd1;
            data2_out      <= op2_final;
            select_ula_out <= select_ula_in;
            rd_out         <= rd_in;
            valid_out      <= 1'b1;
            illegal_op_out <= 1'b0;
        end else if (valid_in) begin
            valid_out      <= 1'b0;
            illegal_op_out <= 1'b1;
        end else begin
            valid_out      <= 1'b0;
            illegal_op_out <= 1'b0;
        end
    end

endmodule
